// File: rtl/l1_cache_maint_arbiter.sv
// Round-robin arbiter that coalesces per-requester L1 clear/flush requests into one cache command.
// Optional cache-response watchdog is compiled in with L1_CACHE_MAINT_TIMEOUT_EN.
module l1_cache_maint_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req_clear,
  input  logic [NUM_REQ-1:0] req_flush,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               cache_clear,
  output logic               cache_flush,
  input  logic               cache_clear_done,
  input  logic               cache_flush_done,
  output logic               busy,
  output logic [CNT_W-1:0]   maint_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W:0]     cand;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] any_req;
  logic               op_flush;
  logic               win_found;
  logic               win_flush;
  logic               match_done;
  logic               timeout_hit;

  // First requester at or after rr_ptr with any request pending, wrapping modulo NUM_REQ.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    any_req   = req_clear | req_flush;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!win_found && any_req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign win_flush  = req_flush[win_idx];
  assign match_done = op_flush ? cache_flush_done : cache_clear_done;
  assign next_ptr   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign busy       = (state != IDLE);

`ifdef L1_CACHE_MAINT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign timeout_hit = (state == BUSY) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  // Counter is held at zero outside BUSY, so it restarts on every BUSY entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt <= '0;
      err     <= '0;
    end else begin
      err     <= (state == BUSY && !match_done && timeout_hit) ? mask : '0;
      tmo_cnt <= (state == BUSY) ? tmo_cnt + TMO_W'(1) : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = '0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      winner      <= '0;
      mask        <= '0;
      op_flush    <= 1'b0;
      done        <= '0;
      cache_clear <= 1'b0;
      cache_flush <= 1'b0;
      maint_count <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          // A done level still high from the previous op must not complete the next one.
          if (win_found && !cache_clear_done && !cache_flush_done) begin
            op_flush    <= win_flush;
            mask        <= win_flush ? req_flush : req_clear;
            winner      <= win_idx;
            cache_flush <= win_flush;
            cache_clear <= !win_flush;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (match_done || timeout_hit) begin
            cache_flush <= 1'b0;
            cache_clear <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= RESP;
            if (match_done) begin
              done <= mask;
              if (maint_count != '1) maint_count <= maint_count + 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cache_maint_arbiter.sv
// Randomized self-checking bench for l1_cache_maint_arbiter against a transaction-level model.
// Small counter width makes saturation reachable; define L1_CACHE_MAINT_TIMEOUT_EN to exercise the watchdog.
module tb_l1_cache_maint_arbiter;

  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  req_clear;
  logic [N-1:0]  req_flush;
  logic [N-1:0]  done;
  logic [N-1:0]  err;
  logic          cache_clear;
  logic          cache_flush;
  logic          cache_clear_done;
  logic          cache_flush_done;
  logic          busy;
  logic [CW-1:0] maint_count;

  l1_cache_maint_arbiter #(
    .NUM_REQ        (N),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .req_clear        (req_clear),
    .req_flush        (req_flush),
    .done             (done),
    .err              (err),
    .cache_clear      (cache_clear),
    .cache_flush      (cache_flush),
    .cache_clear_done (cache_clear_done),
    .cache_flush_done (cache_flush_done),
    .busy             (busy),
    .maint_count      (maint_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rr   = 0;
  int exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // A request line may only fall at an edge where its done or err is high.
  logic [N-1:0] prev_f = '0;
  logic [N-1:0] prev_c = '0;
  always @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (!RST && ((prev_f[i] && !req_flush[i]) || (prev_c[i] && !req_clear[i])))
        assert (done[i] || err[i]) else $error("protocol: requester %0d released early", i);
    end
    prev_f <= req_flush;
    prev_c <= req_clear;
  end

  function automatic int pick_winner(input logic [N-1:0] f, input logic [N-1:0] c, input int rr);
    for (int k = 0; k < N; k++) begin
      if (f[(rr + k) % N] || c[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  // Called at an IDLE negedge with at least one request line high; returns at the next IDLE negedge.
  task automatic do_txn(input int lat, input bit extra_mid);
    int           w;
    bit           op_f;
    logic [N-1:0] m;
    w = pick_winner(req_flush, req_clear, exp_rr);
    if (w < 0) return;
    op_f = req_flush[w];
    m    = op_f ? req_flush : req_clear;
    @(negedge CLK);
    check("cmd_flush", cache_flush, op_f);
    check("cmd_clear", cache_clear, !op_f);
    check("busy_on", busy, 1);
    for (int d = 0; d < lat; d++) begin
      if (extra_mid && d == 0) begin
        req_flush |= N'($urandom) & N'($urandom);
        req_clear |= N'($urandom) & N'($urandom);
      end
      if (op_f) cache_clear_done = 1'($urandom_range(0, 1));
      else      cache_flush_done = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check("cmd_hold", op_f ? cache_flush : cache_clear, 1);
      check("no_overlap", cache_flush & cache_clear, 0);
      check("done_quiet", done, 0);
    end
    cache_flush_done = op_f;
    cache_clear_done = !op_f;
    @(negedge CLK);
    exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
    exp_rr  = (w + 1) % N;
    check("done_mask", done, m);
    check("err_quiet", err, 0);
    check("cmd_drop", {cache_flush, cache_clear}, 0);
    check("count", maint_count, exp_cnt);
    check("busy_resp", busy, 1);
    cache_flush_done = 1'b0;
    cache_clear_done = 1'b0;
    if (op_f) req_flush &= ~m;
    else      req_clear &= ~m;
    @(negedge CLK);
    check("idle_after", busy, 0);
    check("done_gone", done, 0);
  endtask

  initial begin
    RST              = 1'b1;
    req_clear        = '0;
    req_flush        = '0;
    cache_clear_done = 1'b0;
    cache_flush_done = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd", {cache_flush, cache_clear}, 0);
    check("rst_busy", busy, 0);
    check("rst_count", maint_count, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_no_req", busy, 0);

    // Single flush, then a coalesced flush from two requesters.
    req_flush = 4'b0001;
    do_txn(5, 0);
    req_flush = 4'b1010;
    do_txn(2, 0);

    // Steer the pointer back to 0, then flush[0] and clear[1] contend.
    req_clear = 4'b1000;
    do_txn(1, 0);
    req_flush = 4'b0001;
    req_clear = 4'b0010;
    do_txn(3, 0);
    do_txn(0, 0);

    // One requester holding both ops: flush first, clear on a later grant.
    req_flush = 4'b0100;
    req_clear = 4'b0100;
    do_txn(2, 0);
    check("both_clear_kept", req_clear, 4'b0100);
    do_txn(2, 0);

    // A done level left high blocks a new grant until it drops.
    req_clear        = 4'b0001;
    cache_flush_done = 1'b1;
    @(negedge CLK);
    check("stale_block", busy, 0);
    @(negedge CLK);
    check("stale_block_cmd", cache_clear, 0);
    cache_flush_done = 1'b0;
    do_txn(1, 0);

    // Reset in the third BUSY cycle abandons the flush.
    req_flush = 4'b0010;
    @(negedge CLK);
    check("pre_rst_cmd", cache_flush, 1);
    @(negedge CLK);
    @(negedge CLK);
    RST       = 1'b1;
    req_flush = '0;
    @(negedge CLK);
    check("midrst_cmd", cache_flush, 0);
    check("midrst_done", done, 0);
    check("midrst_count", maint_count, 0);
    check("midrst_busy", busy, 0);
    RST     = 1'b0;
    exp_cnt = 0;
    exp_rr  = 0;
    req_clear = 4'b0100;
    do_txn(3, 0);

`ifdef L1_CACHE_MAINT_TIMEOUT_EN
    begin
      bit seen;
      seen      = 1'b0;
      req_clear = 4'b0100;
      for (int c = 0; c < 4 * TMO && !seen; c++) begin
        @(negedge CLK);
        if (err != '0) seen = 1'b1;
      end
      check("tmo_seen", seen, 1);
      check("tmo_err", err, 4'b0100);
      check("tmo_done", done, 0);
      check("tmo_count", maint_count, exp_cnt);
      exp_rr    = (pick_winner('0, 4'b0100, exp_rr) + 1) % N;
      req_clear = '0;
      @(negedge CLK);
      check("tmo_idle", busy, 0);
      check("tmo_err_gone", err, 0);
    end
`endif

    // Random traffic; counter saturation comes into play after a few transactions.
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req_flush[i] = 1'b1;
        if ($urandom_range(0, 3) == 0) req_clear[i] = 1'b1;
      end
      if ((req_flush | req_clear) != '0) begin
        do_txn(int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
      end else begin
        @(negedge CLK);
        check("rand_idle", busy, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
